des_perm_pipe: RTL and testbench



---
 rtl/des_perm_pkg.sv | 50 +++++
 rtl/des_perm_stage.sv | 44 ++++
 rtl/des_perm_pipe.sv | 81 ++++++++
 tb/tb_des_perm_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_perm_pkg.sv
// DES permutation tables, transaction mode encoding and the shared permute helper.
// Bit numbering is DES style: bit 1 is the MSB of a [1:64] vector.
package des_perm_pkg;

    typedef enum logic [1:0] {
        MODE_BYP   = 2'b00,
        MODE_IP    = 2'b01,
        MODE_IPINV = 2'b10,
        MODE_RSV   = 2'b11
    } mode_e;

    // Initial permutation: out[i] = in[IP_TBL[i]]
    localparam int IP_TBL [1:64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    // Final (inverse) permutation: out[i] = in[IP_INV_TBL[i]]
    localparam int IP_INV_TBL [1:64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    // Reserved mode falls through to bypass; the error flag is raised by the caller.
    function automatic logic [1:64] permute(input logic [1:64] data, input mode_e mode);
        logic [1:64] res;
        res = data;
        for (int i = 1; i <= 64; i++) begin
            case (mode)
                MODE_IP:    res[i] = data[IP_TBL[i]];
                MODE_IPINV: res[i] = data[IP_INV_TBL[i]];
                default:    res[i] = data[i];
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One elastic register stage: holds a payload and a valid bit, accepts a new
// payload when empty or when its current payload leaves in the same cycle.
module des_perm_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next state: payload only changes on an actual load so idle inputs never disturb it
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) data_d = in_data_i;
        end
    end

    // Stage registers, cleared by reset so the output shows zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP / IP^-1 / bypass with an elastic valid/ready chain and sideband tag.
// Optional DES_PERM_STATS_EN adds stat_blocks (wrapping) and stat_stalls (saturating).
import des_perm_pkg::*;

module des_perm_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:64]      in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:64]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
`ifdef DES_PERM_STATS_EN
    ,
    output logic [31:0]      stat_blocks,
    output logic [31:0]      stat_stalls
`endif
);

    // Payload layout: {data[1:64], tag, err}
    localparam int PW = 64 + TAG_W + 1;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] rdy_pipe;
    logic [PW-1:0]   pay_pipe [0:STAGES];
    logic [1:64]     perm;
    logic            rsv;

    assign perm        = permute(in_data, mode_e'(in_mode));
    assign rsv         = (mode_e'(in_mode) == MODE_RSV);
    assign vld_pipe[0] = in_valid;
    assign pay_pipe[0] = {perm, in_tag, rsv};
    assign in_ready    = rdy_pipe[0];

    assign rdy_pipe[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        des_perm_stage #(.W(PW)) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (vld_pipe[k]),
            .in_ready_o  (rdy_pipe[k]),
            .in_data_i   (pay_pipe[k]),
            .out_valid_o (vld_pipe[k+1]),
            .out_ready_i (rdy_pipe[k+1]),
            .out_data_o  (pay_pipe[k+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = pay_pipe[STAGES][PW-1 -: 64];
    assign out_tag   = pay_pipe[STAGES][TAG_W:1];
    assign out_err   = pay_pipe[STAGES][0];

`ifdef DES_PERM_STATS_EN
    logic [31:0] blocks_q, stalls_q;

    // Handshake counter wraps; stall counter sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_q <= '0;
            stalls_q <= '0;
        end else begin
            if (out_valid && out_ready) blocks_q <= blocks_q + 32'd1;
            if (out_valid && !out_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_blocks = blocks_q;
    assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe: driver pushes model results, monitor pops on output.
module tb_des_perm_pipe;

    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    typedef struct {
        logic [1:64]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:64]      in_data = '0;
    logic [1:0]       in_mode = 2'b00;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:64]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
`ifdef DES_PERM_STATS_EN
    logic [31:0]      stat_blocks, stat_stalls;
`endif

    int   checks = 0, errors = 0;
    int   hs_cnt = 0, stall_cnt = 0;
    exp_t sb[$];

    des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
`ifdef DES_PERM_STATS_EN
        , .stat_blocks(stat_blocks), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    // DES IP as arithmetic: rows 0..3 start at 58,60,62,64, rows 4..7 at 57..63, step -8 per column
    function automatic int ip_src(int i);
        int r, c;
        r = (i - 1) / 8;
        c = (i - 1) % 8;
        return ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
    endfunction

    // Reference: IP gathers, IP^-1 scatters through the same IP mapping
    function automatic logic [1:64] model(logic [1:64] x, logic [1:0] m);
        logic [1:64] y;
        y = x;
        if (m == 2'b01) for (int i = 1; i <= 64; i++) y[i] = x[ip_src(i)];
        else if (m == 2'b10) for (int j = 1; j <= 64; j++) y[ip_src(j)] = x[j];
        return y;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // One cycle of stimulus, applied at negedge; pushes expectation if accepted
    task automatic drive(bit v, logic [1:64] d, logic [1:0] m, logic [TAG_W-1:0] t, bit ordy,
                         output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; in_mode = m; in_tag = t; out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.data = model(d, m);
            e.tag  = t;
            e.err  = (m == 2'b11);
            sb.push_back(e);
        end
    endtask

    task automatic idle(bit ordy);
        bit a;
        drive(1'b0, {$urandom, $urandom}, 2'($urandom), TAG_W'($urandom), ordy, a);
    endtask

    task automatic send(logic [1:64] d, logic [1:0] m, logic [TAG_W-1:0] t, bit ordy);
        bit a;
        int n;
        n = 0;
        do begin
            drive(1'b1, d, m, t, ordy, a);
            n++;
        end while (!a && n < 100);
        if (!a) chk("send_timeout", 0, 1);
    endtask

    // Directed block: check fixed latency and the literal result while held by backpressure
    task automatic directed(string nm, logic [1:64] d, logic [1:0] m, logic [TAG_W-1:0] t,
                            logic [1:64] expd, bit experr);
        send(d, m, t, 1'b1);
        for (int k = 1; k <= STAGES; k++) begin
            idle(1'b0);
            chk({nm, "_lat"}, out_valid, (k == STAGES));
        end
        chk({nm, "_data"}, out_data, expd);
        chk({nm, "_tag"}, out_tag, t);
        chk({nm, "_err"}, out_err, experr);
    endtask

    // Monitor: compare on every presented output, pop on handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hs_cnt = 0;
                stall_cnt = 0;
            end else if (out_valid) begin
                if (!out_ready) stall_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb[0];
                    chk("sb_data", out_data, e.data);
                    chk("sb_tag", out_tag, e.tag);
                    chk("sb_err", out_err, e.err);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        bit a;
        int n, sent, cyc;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef DES_PERM_STATS_EN
        chk("rst_stat_blocks", stat_blocks, 0);
        chk("rst_stat_stalls", stat_stalls, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors
        directed("ip", 64'h0123456789ABCDEF, 2'b01, 4'd3, 64'hCC00CCFFF0AAF0AA, 1'b0);
        directed("ipinv", 64'hCC00CCFFF0AAF0AA, 2'b10, 4'd5, 64'h0123456789ABCDEF, 1'b0);
        directed("byp", 64'hFEDCBA9876543210, 2'b00, 4'd9, 64'hFEDCBA9876543210, 1'b0);
        directed("rsv", 64'hFEDCBA9876543210, 2'b11, 4'd12, 64'hFEDCBA9876543210, 1'b1);
        repeat (STAGES + 1) idle(1'b1);

        // Full throughput: one accept per cycle with out_ready high
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'($urandom), TAG_W'($urandom), 1'b1, a);
            n += int'(a);
        end
        chk("throughput_accepts", n, 8);
        repeat (STAGES + 1) idle(1'b1);

        // Backpressure: pipe absorbs exactly STAGES blocks
        n = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'($urandom), TAG_W'($urandom), 1'b0, a);
            n += int'(a);
        end
        chk("bp_accepts", n, STAGES);
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < STAGES; i++) idle(1'b1);
        #2;
        chk("bp_drained", sb.size(), 0);
        idle(1'b1);

        // Reset with blocks in flight
        send({$urandom, $urandom}, 2'b01, 4'd1, 1'b0);
        send({$urandom, $urandom}, 2'b10, 4'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
`ifdef DES_PERM_STATS_EN
        chk("midrst_stat_blocks", stat_blocks, 0);
        chk("midrst_stat_stalls", stat_stalls, 0);
`endif
        rst = 1'b0;

        // Random traffic against the scoreboard
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, 2'($urandom), TAG_W'($urandom),
                  ($urandom % 4) != 0, a);
            sent += int'(a);
            cyc++;
        end
        chk("random_sent", sent, 10000);
        n = 0;
        do begin
            idle(1'b1);
            #2;
            n++;
        end while (sb.size() != 0 && n < 100);
        chk("random_drained", sb.size(), 0);
        idle(1'b1);
`ifdef DES_PERM_STATS_EN
        chk("stat_blocks", stat_blocks, 10000);
        chk("stat_stalls", stat_stalls, stall_cnt);
`endif
        chk("handshakes", hs_cnt, 10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
